// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: oversampled SCL/SDA, START/STOP detection,
// 7-bit address match with ACK, and byte delivery over a valid/ready pair.
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       addr_match,
    output logic       nack_drop,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    logic       scl_meta_q, scl_sync_q, scl_prev_q;
    logic       sda_meta_q, sda_sync_q, sda_prev_q;
    logic       scl_meta_d, scl_sync_d, scl_prev_d;
    logic       sda_meta_d, sda_sync_d, sda_prev_d;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_match_q, addr_match_d;
    logic       nack_drop_q, nack_drop_d;
    logic       busy_q, busy_d;

    logic       scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0] byte_w;

    // Input path: two synchronizer stages plus one history stage for edges.
    always_comb begin
        scl_meta_d = scl_in;
        scl_sync_d = scl_meta_q;
        scl_prev_d = scl_sync_q;
        sda_meta_d = sda_in;
        sda_sync_d = sda_meta_q;
        sda_prev_d = sda_sync_q;
    end

    always_ff @(posedge clk) begin
        scl_meta_q <= scl_meta_d;
        scl_sync_q <= scl_sync_d;
        scl_prev_q <= scl_prev_d;
        sda_meta_q <= sda_meta_d;
        sda_sync_q <= sda_sync_d;
        sda_prev_q <= sda_prev_d;
    end

    assign scl_rise = scl_sync_q & ~scl_prev_q;
    assign scl_fall = ~scl_sync_q & scl_prev_q;
    assign start_ev = scl_sync_q & sda_prev_q & ~sda_sync_q;
    assign stop_ev  = scl_sync_q & ~sda_prev_q & sda_sync_q;
    assign byte_w   = {shreg_q[6:0], sda_sync_q};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        sda_oe_d     = sda_oe_q;
        rx_valid_d   = 1'b0;
        addr_match_d = addr_match_q;
        nack_drop_d  = 1'b0;
        busy_d       = busy_q;

        // Bus conditions override any sample landing on the same clock.
        if (stop_ev) begin
            state_d      = IDLE;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
        end else if (start_ev) begin
            state_d      = ADDR;
            bit_cnt_d    = 3'd0;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shreg_d   = byte_w;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                state_d = (byte_w[7:1] == TARGET_ADDR && !byte_w[0])
                                          ? ADDR_ACK : IGNORE;
                            end else if (rx_ready) begin
                                rx_data_d  = byte_w;
                                rx_valid_d = 1'b1;
                                state_d    = DATA_ACK;
                            end else begin
                                nack_drop_d = 1'b1;
                                state_d     = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // sda_oe doubles as the phase flag: first fall drives, second releases.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d     = 1'b1;
                            addr_match_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            state_d   = DATA;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                IGNORE: sda_oe_d = 1'b0;
                IDLE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            rx_data_q    <= 8'h00;
            sda_oe_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            nack_drop_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            sda_oe_q     <= sda_oe_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            nack_drop_q  <= nack_drop_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign addr_match = addr_match_q;
    assign nack_drop  = nack_drop_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master, transaction-level reference
// model feeding a scoreboard queue, and an independent output monitor.
module tb_i2c_target_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic       scl_in, sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       addr_match;
    logic       nack_drop;
    logic       busy;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;  // open-drain wired-AND

    i2c_target_rx dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .addr_match(addr_match),
        .nack_drop (nack_drop),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_drop;
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    logic [7:0] model_last;
    logic [6:0] t_addr;
    bit         t_rw;
    int         t_n;
    logic [7:0] t_data[8];
    bit         t_ready[8];
    bit         exp_ack[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: what the target should do with one whole transaction.
    task automatic model_txn();
        bit accepting;
        ev_t e;
        accepting  = (t_addr == 7'h42) && !t_rw;
        exp_ack[0] = accepting;
        for (int i = 0; i < t_n; i++) begin
            if (accepting && t_ready[i]) begin
                e.is_drop = 1'b0; e.data = t_data[i];
                exp_q.push_back(e);
                model_last   = t_data[i];
                exp_ack[i+1] = 1'b1;
            end else if (accepting) begin
                e.is_drop = 1'b1; e.data = model_last;
                exp_q.push_back(e);
                exp_ack[i+1] = 1'b0;
                accepting    = 1'b0;
            end else begin
                exp_ack[i+1] = 1'b0;
            end
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; clks(5);
        scl_m = 1'b1; clks(10);
        sda_m = 1'b0; clks(10);
        scl_m = 1'b0; clks(5);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; clks(5);
        scl_m = 1'b1; clks(10);
        sda_m = 1'b1; clks(10);
    endtask

    task automatic send_bit(input bit b);
        sda_m = b;    clks(5);
        scl_m = 1'b1; clks(10);
        scl_m = 1'b0; clks(5);
    endtask

    task automatic ack_slot(output bit ack);
        sda_m = 1'b1; clks(5);
        scl_m = 1'b1; clks(5);
        ack = ~sda_in;
        clks(5);
        scl_m = 1'b0; clks(5);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_slot(ack);
    endtask

    task automatic run_txn(input bit end_stop);
        bit a;
        model_txn();
        bus_start();
        chk("busy_after_start", busy, 1);
        send_byte({t_addr, t_rw}, a);
        chk("addr_ack", a, exp_ack[0]);
        chk("addr_match", addr_match, exp_ack[0]);
        for (int i = 0; i < t_n; i++) begin
            rx_ready = t_ready[i];
            send_byte(t_data[i], a);
            chk("data_ack", a, exp_ack[i+1]);
        end
        rx_ready = 1'b1;
        if (end_stop) begin
            bus_stop();
            chk("busy_after_stop", busy, 0);
            chk("addr_match_after_stop", addr_match, 0);
        end
    endtask

    task automatic set_txn(input logic [6:0] a, input bit rw, input int n);
        t_addr = a; t_rw = rw; t_n = n;
        for (int i = 0; i < 8; i++) begin
            t_data[i]  = 8'h00;
            t_ready[i] = 1'b1;
        end
    endtask

    // Monitor: pops one expectation per output pulse, independent of stimulus.
    initial begin
        ev_t e;
        logic oe_prev;
        oe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rx_valid || nack_drop) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output rx_valid=%0b nack_drop=%0b rx_data=%0h expected no output",
                                 rx_valid, nack_drop, rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_kind", {rx_valid, nack_drop}, e.is_drop ? 2'b01 : 2'b10);
                        chk("rx_data", rx_data, e.data);
                    end
                end
                if (sda_oe !== oe_prev) chk("oe_change_while_scl_low", scl_in, 0);
            end
            oe_prev = sda_oe;
        end
    end

    initial begin
        bit a;
        bit last_stop;
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b1; model_last = 8'h00;
        clks(5);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_addr_match", addr_match, 0);
        chk("rst_nack_drop", nack_drop, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        clks(5);

        set_txn(7'h42, 0, 1); t_data[0] = 8'hA5; run_txn(1);
        set_txn(7'h43, 0, 1); t_data[0] = 8'h5A; run_txn(1);
        set_txn(7'h42, 1, 1); t_data[0] = 8'h33; run_txn(1);
        set_txn(7'h42, 0, 3); t_data[0] = 8'h01; t_data[1] = 8'hFF; t_data[2] = 8'h80; run_txn(1);

        set_txn(7'h42, 0, 3); t_data[0] = 8'h11; t_data[1] = 8'h3C; t_data[2] = 8'h77;
        t_ready[1] = 1'b0;
        run_txn(0);
        chk("rx_data_hold_after_drop", rx_data, 8'h11);
        set_txn(7'h42, 0, 1); t_data[0] = 8'h5A; run_txn(1);

        // Reset in the middle of a data byte, then keep clocking the bus.
        bus_start();
        send_byte({7'h42, 1'b0}, a);
        chk("pre_reset_addr_ack", a, 1);
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        reset = 1'b1; clks(3);
        chk("midreset_sda_oe", sda_oe, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_addr_match", addr_match, 0);
        chk("midreset_rx_data", rx_data, 0);
        model_last = 8'h00;
        reset = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(1'b0);
        ack_slot(a);
        chk("post_reset_no_ack", a, 0);
        send_byte(8'hC3, a);
        chk("post_reset_no_ack2", a, 0);
        bus_stop();
        chk("post_reset_busy", busy, 0);
        set_txn(7'h42, 0, 2); t_data[0] = 8'h9E; t_data[1] = 8'h00; run_txn(1);

        last_stop = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_txn(($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h42,
                    ($urandom_range(0, 5) == 0), $urandom_range(1, 4));
            for (int i = 0; i < t_n; i++) begin
                t_data[i]  = 8'($urandom);
                t_ready[i] = ($urandom_range(0, 4) != 0);
            end
            last_stop = (k == 15) ? 1'b1 : ($urandom_range(0, 2) != 0);
            run_txn(last_stop);
        end

        clks(20);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
